// File: rtl/dbnc_pkg.sv
// Shared definitions for the synchronizing debouncer: FSM state encoding,
// registered output bundle, and state-decode helpers.
package dbnc_pkg;

    localparam logic [1:0] ST_LO   = 2'd0;
    localparam logic [1:0] WAIT_HI = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] WAIT_LO = 2'd3;

    typedef struct packed {
        logic dout;
        logic rise;
        logic fall;
        logic busy;
    } dbnc_out_t;

    function automatic logic is_high(input logic [1:0] st);
        return (st == ST_HI) || (st == WAIT_LO);
    endfunction

    function automatic logic is_wait(input logic [1:0] st);
        return (st == WAIT_HI) || (st == WAIT_LO);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '0;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/sync_debounce_edge.sv
// Synchronizes a raw level, qualifies changes over DEBOUNCE_CYCLES stable
// samples, and emits a registered level plus one-cycle rise/fall pulses.
module sync_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic busy
);
    import dbnc_pkg::*;

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s;
    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    dbnc_out_t     o_q, o_nxt;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (din),
        .q     (s)
    );

    // Outputs are registered from next-state decode so they align with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LO;
            cnt   <= '0;
            o_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            o_q   <= o_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_LO: if (s) begin
                state_nxt = WAIT_HI;
                cnt_nxt   = '0;
            end
            WAIT_HI: begin
                if (!s) begin
                    state_nxt = ST_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_HI;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_HI: if (!s) begin
                state_nxt = WAIT_LO;
                cnt_nxt   = '0;
            end
            WAIT_LO: begin
                if (s) begin
                    state_nxt = ST_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = ST_LO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = ST_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_nxt      = '0;
        o_nxt.dout = is_high(state_nxt);
        o_nxt.busy = is_wait(state_nxt);
        o_nxt.rise = (state == WAIT_HI) && (state_nxt == ST_HI);
        o_nxt.fall = (state == WAIT_LO) && (state_nxt == ST_LO);
    end

    assign dout = o_q.dout;
    assign rise = o_q.rise;
    assign fall = o_q.fall;
    assign busy = o_q.busy;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: DEBOUNCE_CYCLES=4 scenarios plus a
// DEBOUNCE_CYCLES=16 random bounce train checked against a run-length model.
module tb_sync_debounce_edge;
    import dbnc_pkg::*;

    logic clk;
    logic rst4, din4, dout4, rise4, fall4, busy4;
    logic rst16, din16, dout16, rise16, fall16, busy16;
    int   checks = 0;
    int   errors = 0;

    sync_debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst4), .din(din4),
        .dout(dout4), .rise(rise4), .fall(fall4), .busy(busy4)
    );

    sync_debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut16 (
        .clk(clk), .rst_n(rst16), .din(din16),
        .dout(dout16), .rise(rise16), .fall(fall16), .busy(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst4 = 1'b0; din4 = 1'b0; rst16 = 1'b0; din16 = 1'b0;
        #2;
        repeat (3) step();
        checks++;
        if ({dout4, rise4, fall4, busy4, dut4.state} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: got %b required 000000", {dout4, rise4, fall4, busy4, dut4.state});
        end
        rst4 = 1'b1; rst16 = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            checks++;
            if ({dout4, rise4, fall4, busy4} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_low edge %0d: got %b required 0000", e, {dout4, rise4, fall4, busy4});
            end
        end
    endtask

    task automatic test_rise();
        logic [3:0] exp;
        din4 = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp = {e >= 7, e == 7, 1'b0, (e >= 3 && e <= 6)};
            checks++;
            if ({dout4, rise4, fall4, busy4} !== exp) begin
                errors++;
                $display("FAIL rise edge %0d: got %b required %b", e, {dout4, rise4, fall4, busy4}, exp);
            end
        end
    endtask

    task automatic test_fall();
        logic [3:0] exp;
        din4 = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp = {e < 7, 1'b0, e == 7, (e >= 3 && e <= 6)};
            checks++;
            if ({dout4, rise4, fall4, busy4} !== exp) begin
                errors++;
                $display("FAIL fall edge %0d: got %b required %b", e, {dout4, rise4, fall4, busy4}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp;
        int rises = 0;
        din4 = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            exp = {1'b0, 1'b0, 1'b0, (e >= 3 && e <= 5)};
            checks++;
            if ({dout4, rise4, fall4, busy4} !== exp) begin
                errors++;
                $display("FAIL bounce edge %0d: got %b required %b", e, {dout4, rise4, fall4, busy4}, exp);
            end
            if (e == 3) din4 = 1'b0;
        end
        din4 = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (rise4 === 1'b1) rises++;
            exp = {e >= 7, e == 7, 1'b0, (e >= 3 && e <= 6)};
            checks++;
            if ({dout4, rise4, fall4, busy4} !== exp) begin
                errors++;
                $display("FAIL bounce_settle edge %0d: got %b required %b", e, {dout4, rise4, fall4, busy4}, exp);
            end
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL bounce_rise_count: got %0d required 1", rises);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp;
        din4 = 1'b0; rst4 = 1'b0;
        step(); step();
        rst4 = 1'b1;
        step();
        din4 = 1'b1;
        repeat (5) step();
        checks++;
        if ({busy4, dut4.state, dut4.cnt} !== {1'b1, WAIT_HI, 2'd2}) begin
            errors++;
            $display("FAIL mid_setup: got busy/state/cnt %b required 1_01_10", {busy4, dut4.state, dut4.cnt});
        end
        rst4 = 1'b0;
        #1;
        checks++;
        if ({dout4, rise4, fall4, busy4, dut4.state, dut4.cnt} !== 8'b0) begin
            errors++;
            $display("FAIL mid_async_reset: got %b required 00000000", {dout4, rise4, fall4, busy4, dut4.state, dut4.cnt});
        end
        for (int e = 1; e <= 3; e++) begin
            step();
            checks++;
            if ({dout4, rise4, fall4, busy4} !== 4'b0000) begin
                errors++;
                $display("FAIL mid_in_reset edge %0d: got %b required 0000", e, {dout4, rise4, fall4, busy4});
            end
        end
        rst4 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            exp = {e >= 7, e == 7, 1'b0, (e >= 3 && e <= 6)};
            checks++;
            if ({dout4, rise4, fall4, busy4} !== exp) begin
                errors++;
                $display("FAIL mid_release edge %0d: got %b required %b", e, {dout4, rise4, fall4, busy4}, exp);
            end
        end
    endtask

    // Model: dout flips once the synchronized input has disagreed with it on
    // DEBOUNCE_CYCLES+1 consecutive sampling edges.
    task automatic test_random();
        logic m_d1 = 1'b0, m_s = 1'b0, m_dout = 1'b0, samp;
        logic m_rise, m_fall;
        int   run = 0, rises = 0, falls = 0, w;
        logic lvl;
        for (int p = 0; p < 14; p++) begin
            lvl = (p % 2 == 0);
            w   = $urandom_range(15, 1);
            for (int c = 0; c <= w + 60; c++) begin
                if (p == 13) din16 = 1'b1;
                else if (c >= w) break;
                else din16 = lvl;
                step();
                samp = m_s; m_s = m_d1; m_d1 = din16;
                m_rise = 1'b0; m_fall = 1'b0;
                if (samp != m_dout) begin
                    run++;
                    if (run == 17) begin
                        m_dout = samp; run = 0;
                        m_rise = samp; m_fall = !samp;
                    end
                end else begin
                    run = 0;
                end
                if (rise16 === 1'b1) rises++;
                if (fall16 === 1'b1) falls++;
                checks++;
                if ({dout16, rise16, fall16, busy16} !== {m_dout, m_rise, m_fall, run > 0}) begin
                    errors++;
                    $display("FAIL random p%0d c%0d: got %b required %b", p, c,
                             {dout16, rise16, fall16, busy16}, {m_dout, m_rise, m_fall, run > 0});
                end
            end
        end
        checks++;
        if ({rises, falls, dout16} !== {32'd1, 32'd0, 1'b1}) begin
            errors++;
            $display("FAIL random_edges: got rises=%0d falls=%0d dout=%b required 1 0 1", rises, falls, dout16);
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_bounce();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
